// File: rtl/target_bbox_detec.sv
// target_bbox_detec: per-frame bounding box of foreground pixels in a 1-bit
// video stream. Tracks min/max column and row of in-region foreground pixels
// and the pixel count, then publishes them with a one-cycle strobe at frame end.
module target_bbox_detec #(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int BORDER     = 1,
   parameter int MIN_PIXELS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pre_img_vsync,
   input  logic        pre_img_hsync,
   input  logic        pre_img_valid,
   input  logic        pre_img_data,
   output logic [10:0] bbox_x_min,
   output logic [10:0] bbox_x_max,
   output logic [10:0] bbox_y_min,
   output logic [10:0] bbox_y_max,
   output logic [19:0] bbox_pix_cnt,
   output logic        bbox_found,
   output logic        bbox_valid
);

   localparam logic [10:0] COL_END  = 11'(IMG_WIDTH);
   localparam logic [10:0] ROW_END  = 11'(IMG_HEIGHT);
   localparam logic [10:0] COL_HI   = 11'(IMG_WIDTH - 1 - BORDER);
   localparam logic [10:0] ROW_HI   = 11'(IMG_HEIGHT - 1 - BORDER);
   localparam logic [11:0] LO_BOUND = 12'(BORDER);
   localparam logic [19:0] CNT_MAX  = 20'hF_FFFF;
   localparam logic [19:0] MIN_CNT  = 20'(MIN_PIXELS);
   localparam logic [10:0] MIN_INIT = 11'h7FF;

   // Sync history and frame/line tracking.
   logic        vsync_q, hsync_q;
   logic        in_frame_q, in_frame_d;
   logic        line_seen_q, line_seen_d;
   logic [10:0] col_q, col_d;
   logic [10:0] row_q, row_d;

   // Per-frame accumulators.
   logic [10:0] acc_x_min_q, acc_x_min_d;
   logic [10:0] acc_x_max_q, acc_x_max_d;
   logic [10:0] acc_y_min_q, acc_y_min_d;
   logic [10:0] acc_y_max_q, acc_y_max_d;
   logic [19:0] acc_cnt_q, acc_cnt_d;

   // Published results.
   logic [10:0] out_x_min_q, out_x_min_d;
   logic [10:0] out_x_max_q, out_x_max_d;
   logic [10:0] out_y_min_q, out_y_min_d;
   logic [10:0] out_y_max_q, out_y_max_d;
   logic [19:0] out_cnt_q, out_cnt_d;
   logic        out_found_q, out_found_d;
   logic        out_valid_q, out_valid_d;

   logic frame_start, frame_end, line_end;
   logic pix_take, in_region, fg_hit;

   assign frame_start = pre_img_vsync & ~vsync_q;
   // Only a frame whose start was seen may end; this also discards a frame
   // already in flight when reset is released.
   assign frame_end   = ~pre_img_vsync & vsync_q & in_frame_q;
   assign line_end    = ~pre_img_hsync & hsync_q;
   // A valid pixel arriving on the frame-end edge has vsync already low.
   assign pix_take    = in_frame_q & pre_img_vsync & pre_img_valid;

   // Lower bounds compared as (pos + 1 > BORDER) so BORDER = 0 never forms
   // an always-true unsigned compare against zero.
   assign in_region = (({1'b0, col_q} + 12'd1) > LO_BOUND) && (col_q <= COL_HI) &&
                      (({1'b0, row_q} + 12'd1) > LO_BOUND) && (row_q <= ROW_HI);
   assign fg_hit    = pix_take & pre_img_data & in_region;

   // Frame flag and column/row position of the current pixel.
   always_comb begin
      // NOTE: every _d gets its hold value first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      in_frame_d  = in_frame_q;
      line_seen_d = line_seen_q;
      col_d       = col_q;
      row_d       = row_q;

      if (frame_start) begin
         in_frame_d = 1'b1;
      end else if (frame_end) begin
         in_frame_d = 1'b0;
      end

      if (frame_start || line_end) begin
         col_d       = '0;
         line_seen_d = 1'b0;
      end else if (pix_take) begin
         line_seen_d = 1'b1;
         if (col_q != COL_END) begin
            col_d = col_q + 11'd1;
         end
      end

      if (frame_start) begin
         row_d = '0;
      end else if (line_end && in_frame_q && (line_seen_q || pix_take) &&
                   (row_q != ROW_END)) begin
         row_d = row_q + 11'd1;
      end
   end

   // Compare-and-update of the box accumulators, cleared at frame start.
   always_comb begin
      acc_x_min_d = acc_x_min_q;
      acc_x_max_d = acc_x_max_q;
      acc_y_min_d = acc_y_min_q;
      acc_y_max_d = acc_y_max_q;
      acc_cnt_d   = acc_cnt_q;

      if (frame_start) begin
         acc_x_min_d = MIN_INIT;
         acc_x_max_d = '0;
         acc_y_min_d = MIN_INIT;
         acc_y_max_d = '0;
         acc_cnt_d   = '0;
      end else if (fg_hit) begin
         if (col_q < acc_x_min_q) acc_x_min_d = col_q;
         if (col_q > acc_x_max_q) acc_x_max_d = col_q;
         if (row_q < acc_y_min_q) acc_y_min_d = row_q;
         if (row_q > acc_y_max_q) acc_y_max_d = row_q;
         if (acc_cnt_q != CNT_MAX) acc_cnt_d = acc_cnt_q + 20'd1;
      end
   end

   // Publish the accumulators at frame end; hold otherwise.
   always_comb begin
      out_x_min_d = out_x_min_q;
      out_x_max_d = out_x_max_q;
      out_y_min_d = out_y_min_q;
      out_y_max_d = out_y_max_q;
      out_cnt_d   = out_cnt_q;
      out_found_d = out_found_q;
      out_valid_d = 1'b0;

      if (frame_end) begin
         out_valid_d = 1'b1;
         out_cnt_d   = acc_cnt_q;
         if (acc_cnt_q >= MIN_CNT) begin
            out_x_min_d = acc_x_min_q;
            out_x_max_d = acc_x_max_q;
            out_y_min_d = acc_y_min_q;
            out_y_max_d = acc_y_max_q;
            out_found_d = 1'b1;
         end else begin
            out_x_min_d = '0;
            out_x_max_d = '0;
            out_y_min_d = '0;
            out_y_max_d = '0;
            out_found_d = 1'b0;
         end
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: vsync history resets high so a vsync still high at reset
         // release is not mistaken for a frame start.
         vsync_q     <= 1'b1;
         hsync_q     <= 1'b0;
         in_frame_q  <= 1'b0;
         line_seen_q <= 1'b0;
         col_q       <= '0;
         row_q       <= '0;
         acc_x_min_q <= MIN_INIT;
         acc_x_max_q <= '0;
         acc_y_min_q <= MIN_INIT;
         acc_y_max_q <= '0;
         acc_cnt_q   <= '0;
         out_x_min_q <= '0;
         out_x_max_q <= '0;
         out_y_min_q <= '0;
         out_y_max_q <= '0;
         out_cnt_q   <= '0;
         out_found_q <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values.
         vsync_q     <= pre_img_vsync;
         hsync_q     <= pre_img_hsync;
         in_frame_q  <= in_frame_d;
         line_seen_q <= line_seen_d;
         col_q       <= col_d;
         row_q       <= row_d;
         acc_x_min_q <= acc_x_min_d;
         acc_x_max_q <= acc_x_max_d;
         acc_y_min_q <= acc_y_min_d;
         acc_y_max_q <= acc_y_max_d;
         acc_cnt_q   <= acc_cnt_d;
         out_x_min_q <= out_x_min_d;
         out_x_max_q <= out_x_max_d;
         out_y_min_q <= out_y_min_d;
         out_y_max_q <= out_y_max_d;
         out_cnt_q   <= out_cnt_d;
         out_found_q <= out_found_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bbox_x_min   = out_x_min_q;
   assign bbox_x_max   = out_x_max_q;
   assign bbox_y_min   = out_y_min_q;
   assign bbox_y_max   = out_y_max_q;
   assign bbox_pix_cnt = out_cnt_q;
   assign bbox_found   = out_found_q;
   assign bbox_valid   = out_valid_q;

endmodule

// File: tb/tb_target_bbox_detec.sv
// Directed bench for target_bbox_detec on a reduced 32x24 image. Three
// instances share the stimulus: A (BORDER=1, MIN=16), B (BORDER=1, MIN=1),
// C (BORDER=0, MIN=16).
module tb_target_bbox_detec;

   localparam int W = 32;
   localparam int H = 24;

   logic clk = 1'b0;
   logic rst_n;
   logic vs, hs, va, da;

   logic [10:0] x_min [3];
   logic [10:0] x_max [3];
   logic [10:0] y_min [3];
   logic [10:0] y_max [3];
   logic [19:0] pcnt  [3];
   logic        found [3];
   logic        bvld  [3];

   int passed = 0;
   int total  = 0;
   int strobe_cnt = 0;

   always #5 clk = ~clk;

   target_bbox_detec #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(1), .MIN_PIXELS(16)) u_a (
      .clk(clk), .rst_n(rst_n), .pre_img_vsync(vs), .pre_img_hsync(hs),
      .pre_img_valid(va), .pre_img_data(da),
      .bbox_x_min(x_min[0]), .bbox_x_max(x_max[0]), .bbox_y_min(y_min[0]),
      .bbox_y_max(y_max[0]), .bbox_pix_cnt(pcnt[0]), .bbox_found(found[0]),
      .bbox_valid(bvld[0]));

   target_bbox_detec #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(1), .MIN_PIXELS(1)) u_b (
      .clk(clk), .rst_n(rst_n), .pre_img_vsync(vs), .pre_img_hsync(hs),
      .pre_img_valid(va), .pre_img_data(da),
      .bbox_x_min(x_min[1]), .bbox_x_max(x_max[1]), .bbox_y_min(y_min[1]),
      .bbox_y_max(y_max[1]), .bbox_pix_cnt(pcnt[1]), .bbox_found(found[1]),
      .bbox_valid(bvld[1]));

   target_bbox_detec #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(0), .MIN_PIXELS(16)) u_c (
      .clk(clk), .rst_n(rst_n), .pre_img_vsync(vs), .pre_img_hsync(hs),
      .pre_img_valid(va), .pre_img_data(da),
      .bbox_x_min(x_min[2]), .bbox_x_max(x_max[2]), .bbox_y_min(y_min[2]),
      .bbox_y_max(y_max[2]), .bbox_pix_cnt(pcnt[2]), .bbox_found(found[2]),
      .bbox_valid(bvld[2]));

   // Count result strobes of instance A (each pulse spans one negedge).
   always @(negedge clk) begin
      if (bvld[0] === 1'b1) strobe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_res(input string tag, input int k, input int xn, input int xx,
                            input int yn, input int yx, input int cnt,
                            input logic fnd, input logic vld);
      check({tag, ".valid"}, 32'(bvld[k]),  32'(vld));
      check({tag, ".x_min"}, 32'(x_min[k]), 32'(xn));
      check({tag, ".x_max"}, 32'(x_max[k]), 32'(xx));
      check({tag, ".y_min"}, 32'(y_min[k]), 32'(yn));
      check({tag, ".y_max"}, 32'(y_max[k]), 32'(yx));
      check({tag, ".cnt"},   32'(pcnt[k]),  32'(cnt));
      check({tag, ".found"}, 32'(found[k]), 32'(fnd));
   endtask

   function automatic logic pix(input int mode, input int r, input int c);
      case (mode)
         0: return (c >= 10 && c <= 19 && r >= 5 && r <= 8);
         1: return (r == 0 || r == H - 1 || c == 0 || c == W - 1) ||
                   (r == 12 && c >= 15 && c <= 24);
         2: return (r == 22 && c == 30);
         3: return (c >= 3 && c <= 6 && r >= 2 && r <= 6);
         4: return (c >= 20 && c <= 27 && r >= 10 && r <= 13);
         5: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Called at a negedge: raises vsync now, streams the lines, and drops
   // vsync (with hsync) right after the last pixel. rst_row >= 0 pulses
   // reset at the start of that row.
   task automatic run_frame(input int mode, input int rst_row);
      int nr;
      int np;
      vs = 1'b1; hs = 1'b0; va = 1'b0; da = 1'b0;
      nr = (mode == 2) ? H - 1 : H;
      for (int r = 0; r < nr; r++) begin
         if (mode == 2 && r == nr - 1) np = W - 1;
         else if (mode == 5 && r == 3) np = 801;
         else np = W;
         for (int c = 0; c < np; c++) begin
            @(negedge clk);
            if (r == rst_row && c == 2) begin
               check("rst_mid.x_max", 32'(x_max[0]), 32'd0);
               check("rst_mid.cnt",   32'(pcnt[0]),  32'd0);
            end
            hs = 1'b1; va = 1'b1; da = pix(mode, r, c);
            if (r == rst_row && c == 0) rst_n = 1'b0;
            if (r == rst_row && c == 4) rst_n = 1'b1;
         end
         if (r != nr - 1) begin
            repeat (2) begin
               @(negedge clk);
               hs = 1'b0; va = 1'b0; da = 1'b0;
            end
         end
      end
      @(negedge clk);
      vs = 1'b0; hs = 1'b0; va = 1'b0; da = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      vs = 1'b0; hs = 1'b0; va = 1'b0; da = 1'b0;
      repeat (3) @(negedge clk);
      check_res("reset_a", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      check_res("reset_c", 2, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // Solid block cols 10..19, rows 5..8.
      run_frame(0, -1);
      @(negedge clk);
      check_res("blk", 0, 10, 19, 5, 8, 40, 1'b1, 1'b1);
      @(negedge clk);
      check_res("blk_hold", 0, 10, 19, 5, 8, 40, 1'b1, 1'b0);

      // Border ring plus 10 interior pixels.
      @(negedge clk);
      run_frame(1, -1);
      @(negedge clk);
      check_res("sobel", 0, 0, 0, 0, 0, 10, 1'b0, 1'b1);
      check_res("sobel_b0", 2, 0, 31, 0, 23, 118, 1'b1, 1'b1);

      // Single pixel on the last valid cycle before vsync falls.
      repeat (2) @(negedge clk);
      run_frame(2, -1);
      @(negedge clk);
      check_res("last_px", 1, 30, 30, 22, 22, 1, 1'b1, 1'b1);
      check_res("last_px_min16", 0, 0, 0, 0, 0, 1, 1'b0, 1'b1);

      // Box A then box B with a one-cycle vsync gap.
      repeat (2) @(negedge clk);
      run_frame(3, -1);
      @(negedge clk);
      check_res("box_a", 0, 3, 6, 2, 6, 20, 1'b1, 1'b1);
      run_frame(4, -1);
      @(negedge clk);
      check_res("box_b", 0, 20, 27, 10, 13, 32, 1'b1, 1'b1);

      // All ones, with an 801-pixel line at row 3.
      repeat (2) @(negedge clk);
      run_frame(5, -1);
      @(negedge clk);
      check_res("ones_b0", 2, 0, 31, 0, 23, 768, 1'b1, 1'b1);
      check_res("ones_b1", 0, 1, 30, 1, 22, 660, 1'b1, 1'b1);

      // Reset asserted and released inside a frame: no result for it.
      repeat (2) @(negedge clk);
      run_frame(0, 10);
      @(negedge clk);
      check_res("rst_frame", 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      run_frame(0, -1);
      @(negedge clk);
      check_res("after_rst", 0, 10, 19, 5, 8, 40, 1'b1, 1'b1);

      @(negedge clk);
      check("strobes", 32'(strobe_cnt), 32'd7);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/target_bbox_detec.md
# target_bbox_detec

Frame-level bounding-box extractor for the frame_diff pipeline. Consumes the 1-bit binary edge/motion stream produced by the Sobel stage (vsync/hsync/valid/data) and tracks per frame the min/max column and row of all foreground pixels outside a configurable border. At each frame end it publishes the box, foreground pixel count, and a found flag, with a one-cycle result strobe for the downstream overlay/tracking logic.

## Interface
- IMG_WIDTH, 640, active pixels per line
- IMG_HEIGHT, 480, active lines per frame
- BORDER, 1, pixels ignored at each image edge (Sobel forces border pixels to 1)
- MIN_PIXELS, 16, minimum in-region foreground count for bbox_found=1
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- pre_img_vsync  in  1  high for the whole active frame
- pre_img_hsync  in  1  high for the whole active line
- pre_img_valid  in  1  pixel qualifier
- pre_img_data  in  1  foreground pixel (1 = edge/motion)
- bbox_x_min, bbox_x_max  out  11  column bounds, 0-based
- bbox_y_min, bbox_y_max  out  11  row bounds, 0-based
- bbox_pix_cnt  out  20  foreground pixels counted in region, saturating
- bbox_found  out  1  bbox_pix_cnt >= MIN_PIXELS for last frame
- bbox_valid  out  1  one-cycle strobe, results updated

## Operation
- Edge detect: vsync_d, hsync_d registers; frame start = vsync 0->1, frame end = vsync 1->0, line end = hsync 1->0.
- in_frame flag: set on frame start, cleared on frame end; stream ignored while in_frame=0 (frame in progress at reset release discarded).
- col counter: increments on each valid pixel while in_frame; cleared on line end and frame start; holds at IMG_WIDTH (extra pixels ignored).
- row counter: cleared on frame start; on line end increments if >=1 valid pixel seen in that line; holds at IMG_HEIGHT.
- Pixel in region iff BORDER <= col <= IMG_WIDTH-1-BORDER and BORDER <= row <= IMG_HEIGHT-1-BORDER.
- Foreground in-region pixel: x_min=min(x_min,col), x_max=max(x_max,col), same for y; pix_cnt+1, saturating at 2^20-1.
- Accumulator init (reset, frame start): x_min=y_min=2047, x_max=y_max=0, pix_cnt=0.
- Frame end: if pix_cnt >= MIN_PIXELS, outputs load accumulators, bbox_found=1; else all coords 0, bbox_found=0, bbox_pix_cnt=pix_cnt. bbox_valid=1 for one cycle.
- Outputs hold between frame ends.
- Valid pixel sampled on frame-end edge (vsync already 0) ignored.
- Simultaneous line end and frame end: row update irrelevant; frame result uses accumulators as of preceding cycle.

## Timing
- Reset values: all outputs 0; accumulators at init; in_frame=0; counters 0.
- Pixel-to-accumulator latency: 1 cycle (registered compare-update).
- Result latency: outputs and bbox_valid change on the clock edge that first samples pre_img_vsync=0 after 1; last pixel may be on the immediately preceding edge and must be included (bypass/forward if compare is pipelined).
- Back-to-back frames: vsync low for 1 cycle between frames must yield a correct result strobe and cleared accumulators for the next frame.
- Reset mid-frame: immediate clear; no bbox_valid until a full frame (rising and falling vsync edge) observed.

## Test plan
- 640x480 frame, foreground block cols 100..149, rows 50..89, rest 0 -> bbox_valid 1 cycle after vsync fall; x 100/149, y 50/89, pix_cnt 2000, found=1.
- Sobel-style frame: border ring all 1, 10 interior pixels at (300,200) line -> pix_cnt 10 < 16, found=0, coords 0; border pixels never counted.
- Single foreground pixel at last valid cycle of frame (col 638,row 478, BORDER=1) with MIN_PIXELS=1 -> x_min=x_max=638, y_min=y_max=478, found=1.
- Two consecutive frames, 1-cycle vsync gap, box A then box B -> second strobe reports only box B.
- Assert rst_n low mid-frame, release mid-frame -> no strobe for that frame; next full frame reported correctly.
- All-ones frame with BORDER=0 -> x 0/639, y 0/479, pix_cnt 307200, found=1; 801 valid pixels on one line -> col holds, no wrap.
